// File: rtl/mwadd_pkg.sv
// Shared types and default widths for the multi-word adder sequencer.
package mwadd_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/carry_look_ahead_adder.sv
// Generate/propagate adder of configurable width with carry-in and carry-out.
module carry_look_ahead_adder #(
  parameter int unsigned data_width = 32
) (
  input  logic [data_width-1:0] a,
  input  logic [data_width-1:0] b,
  input  logic                  cin,
  output logic [data_width-1:0] sum,
  output logic                  cout
);

  logic [data_width-1:0] g;
  logic [data_width-1:0] p;
  logic [data_width:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < data_width; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum  = p ^ c[data_width-1:0];
  assign cout = c[data_width];

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-precision add sequencer: streams LS-first word pairs through one adder, chaining carry.
// Optional subtract mode is built when MWADD_SUB_EN is defined.
module multiword_add_seq
  import mwadd_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_cin,
  input  logic              cmd_sub,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_sum,
  output logic              res_last,
  output logic              res_cout,
  output logic              res_ovf,
  output logic              busy
);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   cnt_r;
  logic               carry_r;
  logic [DATA_W-1:0]  b_eff;
  logic [DATA_W-1:0]  sum_w;
  logic               carry_w;
  logic               carry_init;
  logic               cout_w;
  logic               ovf_w;
  logic               cmd_fire;
  logic               op_fire;
  logic               res_fire;
  logic               last_beat;

`ifdef MWADD_SUB_EN
  logic sub_r;

  // Subtraction is a + ~b + 1: borrow-in maps to an inverted initial carry,
  // and borrow-out is the inverted final carry.
  assign b_eff      = sub_r ? ~op_b : op_b;
  assign carry_init = cmd_sub ? ~cmd_cin : cmd_cin;
  assign cout_w     = sub_r ? ~carry_w : carry_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sub_r <= 1'b0;
    end else if (cmd_fire) begin
      sub_r <= cmd_sub;
    end
  end
`else
  logic unused_sub;

  assign unused_sub = cmd_sub;
  assign b_eff      = op_b;
  assign carry_init = cmd_cin;
  assign cout_w     = carry_w;
`endif

  carry_look_ahead_adder #(
    .data_width(DATA_W)
  ) u_adder (
    .a    (op_a),
    .b    (b_eff),
    .cin  (carry_r),
    .sum  (sum_w),
    .cout (carry_w)
  );

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign op_fire   = op_valid & op_ready;
  assign res_fire  = res_valid & res_ready;
  assign last_beat = (cnt_r == len_r);
  assign ovf_w     = (op_a[DATA_W-1] ~^ b_eff[DATA_W-1]) & (sum_w[DATA_W-1] ^ op_a[DATA_W-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    op_ready  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        op_ready = !res_valid || res_ready;
        if (op_valid && op_ready && last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (res_valid && res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_r     <= '0;
      cnt_r     <= '0;
      carry_r   <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_last  <= 1'b0;
      res_cout  <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      if (cmd_fire) begin
        len_r   <= cmd_len;
        cnt_r   <= '0;
        carry_r <= carry_init;
      end
      // A new beat may load while the previous one drains in the same cycle.
      if (op_fire) begin
        res_valid <= 1'b1;
        res_sum   <= sum_w;
        carry_r   <= carry_w;
        cnt_r     <= cnt_r + 1'b1;
        res_last  <= last_beat;
        res_cout  <= last_beat & cout_w;
        res_ovf   <= last_beat & ovf_w;
      end else if (res_fire) begin
        res_valid <= 1'b0;
        res_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed, table-driven bench for multiword_add_seq plus hand-written multi-cycle sequences.
module tb_multiword_add_seq;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned NW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_cin, cmd_sub;
  logic [LW-1:0] cmd_len;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic          res_valid, res_ready, res_last, res_cout, res_ovf, busy;
  logic [DW-1:0] res_sum;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic [LW-1:0]         len;
    logic                  cin;
    logic                  sub;
    logic [NW-1:0][DW-1:0] a;
    logic [NW-1:0][DW-1:0] b;
    logic [NW-1:0][DW-1:0] sum;
    logic                  cout;
    logic                  ovf;
  } vec_t;

  vec_t vecs[8];
  int   n_vec;

  multiword_add_seq #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_cin(cmd_cin), .cmd_sub(cmd_sub),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_last(res_last), .res_cout(res_cout), .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting, got 0 expected 1", name);
  endtask

  // Called at a negedge; issues a command and returns at the negedge after the handshake.
  task automatic start_cmd(input logic [LW-1:0] len, input logic cin, input logic sub);
    int unsigned k = 0;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) timeout("cmd_ready");
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_cin   = cin;
    cmd_sub   = sub;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] exp_sum, input logic exp_last);
    int unsigned k = 0;
    while (!op_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!op_ready) timeout({name, " op_ready"});
    op_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    op_valid = 1'b0;
    chk({name, " res_valid"}, DW'(res_valid), DW'(1));
    chk({name, " res_sum"}, res_sum, exp_sum);
    chk({name, " res_last"}, DW'(res_last), DW'(exp_last));
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    cmd_cin   = 1'b0;
    cmd_sub   = 1'b0;
    op_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    res_ready = 1'b1;

    for (int i = 0; i < 8; i++) vecs[i] = '{default: '0};
    // 0: single word wrap with carry-out
    vecs[0].len = 0; vecs[0].a[0] = 32'hFFFF_FFFF; vecs[0].b[0] = 32'h1;
    vecs[0].sum[0] = 32'h0; vecs[0].cout = 1'b1; vecs[0].ovf = 1'b0;
    // 1: carry propagates across three words
    vecs[1].len = 2;
    vecs[1].a[0] = 32'hFFFF_FFFF; vecs[1].a[1] = 32'hFFFF_FFFF; vecs[1].a[2] = 32'h0;
    vecs[1].b[0] = 32'h1;
    vecs[1].sum[0] = 32'h0; vecs[1].sum[1] = 32'h0; vecs[1].sum[2] = 32'h1;
    vecs[1].cout = 1'b0; vecs[1].ovf = 1'b0;
    // 2: positive signed overflow
    vecs[2].len = 0; vecs[2].a[0] = 32'h7FFF_FFFF; vecs[2].b[0] = 32'h1;
    vecs[2].sum[0] = 32'h8000_0000; vecs[2].cout = 1'b0; vecs[2].ovf = 1'b1;
    // 3: carry-in used, overflow on top word
    vecs[3].len = 1; vecs[3].cin = 1'b1;
    vecs[3].a[0] = 32'hFFFF_FFFF; vecs[3].a[1] = 32'h7FFF_FFFF;
    vecs[3].sum[0] = 32'h0; vecs[3].sum[1] = 32'h8000_0000;
    vecs[3].cout = 1'b0; vecs[3].ovf = 1'b1;
    // 4: negative overflow with carry-out
    vecs[4].len = 0; vecs[4].a[0] = 32'h8000_0000; vecs[4].b[0] = 32'h8000_0000;
    vecs[4].sum[0] = 32'h0; vecs[4].cout = 1'b1; vecs[4].ovf = 1'b1;
    // 5: maximum length, 16 words, carry-in ripples through all of them
    vecs[5].len = 4'hF; vecs[5].cin = 1'b1;
    for (int i = 0; i < 16; i++) vecs[5].a[i] = 32'hFFFF_FFFF;
    vecs[5].cout = 1'b1; vecs[5].ovf = 1'b0;
    // 6: sub request: 5-3 when subtract is built, otherwise ignored and 5+3
    vecs[6].len = 0; vecs[6].sub = 1'b1; vecs[6].a[0] = 32'h5; vecs[6].b[0] = 32'h3;
`ifdef MWADD_SUB_EN
    vecs[6].sum[0] = 32'h2;
`else
    vecs[6].sum[0] = 32'h8;
`endif
    vecs[6].cout = 1'b0; vecs[6].ovf = 1'b0;
    n_vec = 7;
`ifdef MWADD_SUB_EN
    // 7: two-word subtract with borrow across the word boundary
    vecs[7].len = 1; vecs[7].sub = 1'b1;
    vecs[7].a[0] = 32'h0; vecs[7].a[1] = 32'h1;
    vecs[7].b[0] = 32'h1; vecs[7].b[1] = 32'h0;
    vecs[7].sum[0] = 32'hFFFF_FFFF; vecs[7].sum[1] = 32'h0;
    vecs[7].cout = 1'b0; vecs[7].ovf = 1'b0;
    n_vec = 8;
`endif

    repeat (2) @(negedge clk);
    chk("rst cmd_ready", DW'(cmd_ready), DW'(1));
    chk("rst op_ready", DW'(op_ready), DW'(0));
    chk("rst res_valid", DW'(res_valid), DW'(0));
    chk("rst res_sum", res_sum, 32'h0);
    chk("rst flags", DW'({res_last, res_cout, res_ovf, busy}), DW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // op_valid in IDLE must not produce a result
    op_valid = 1'b1; op_a = 32'h1; op_b = 32'h1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("idle op ignored", DW'(res_valid), DW'(0));

    for (int v = 0; v < n_vec; v++) begin
      start_cmd(vecs[v].len, vecs[v].cin, vecs[v].sub);
      chk($sformatf("v%0d busy", v), DW'(busy), DW'(1));
      for (int w = 0; w <= int'(vecs[v].len); w++) begin
        send_word($sformatf("v%0d w%0d", v, w), vecs[v].a[w], vecs[v].b[w], vecs[v].sum[w],
                  w == int'(vecs[v].len));
      end
      chk($sformatf("v%0d cout", v), DW'(res_cout), DW'(vecs[v].cout));
      chk($sformatf("v%0d ovf", v), DW'(res_ovf), DW'(vecs[v].ovf));
      @(negedge clk);
      chk($sformatf("v%0d idle", v), DW'({busy, res_valid, cmd_ready}), DW'(1));
    end

    // Backpressure: stall the result stream for 3 cycles after beat 2
    start_cmd(4'd3, 1'b0, 1'b0);
    send_word("bp w0", 32'd1, 32'd10, 32'd11, 1'b0);
    send_word("bp w1", 32'd2, 32'd20, 32'd22, 1'b0);
    res_ready = 1'b0;
    op_valid  = 1'b1; op_a = 32'd3; op_b = 32'd30;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d sum", i), res_sum, 32'd22);
      chk($sformatf("bp hold%0d op_ready", i), DW'(op_ready), DW'(0));
      chk($sformatf("bp hold%0d valid", i), DW'(res_valid), DW'(1));
    end
    res_ready = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    chk("bp w2 sum", res_sum, 32'd33);
    chk("bp w2 last", DW'(res_last), DW'(0));
    send_word("bp w3", 32'd4, 32'd40, 32'd44, 1'b1);
    chk("bp cout", DW'(res_cout), DW'(0));
    @(negedge clk);

    // Reset in the middle of a 4-word operation
    start_cmd(4'd3, 1'b1, 1'b0);
    send_word("rm w0", 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    send_word("rm w1", 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rm res_valid", DW'(res_valid), DW'(0));
    chk("rm busy", DW'(busy), DW'(0));
    chk("rm cmd_ready", DW'(cmd_ready), DW'(1));
    chk("rm op_ready", DW'(op_ready), DW'(0));
    start_cmd(4'd0, 1'b0, 1'b0);
    send_word("rm new", 32'h5, 32'h3, 32'h8, 1'b1);
    chk("rm new cout", DW'(res_cout), DW'(0));
    @(negedge clk);
    chk("rm end idle", DW'({busy, res_valid}), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
